// File: rtl/baby_vga_pkg.sv
// Shared definitions for the baby_vga framebuffer write path: default
// geometry, write pacing and the write scheduler's state encoding.
package baby_vga_pkg;

    localparam int FB_ADDR_BITS   = 4;
    localparam int FB_HOLD_CYCLES = 8;
    localparam int FB_DATA_W      = 32;
    localparam int FB_CNT_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_HOLD  = 2'b10
    } fb_state_e;

endpackage : baby_vga_pkg

// File: rtl/fb_rr_arbiter.sv
// Two-requester round-robin arbiter (CPU vs. fill engine). A lone requester
// always wins; on contention the requester that did not win last time is
// granted. Out of reset the fill is treated as the last winner so the CPU
// takes the first contended grant.
module fb_rr_arbiter (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic req_cpu_i,
    input  logic req_fill_i,
    output logic gnt_cpu_o,
    output logic gnt_fill_o
);

    logic last_fill_q;
    logic last_fill_d;

    // Grant decision for the current cycle, only while the scheduler is idle.
    always_comb begin
        gnt_cpu_o  = 1'b0;
        gnt_fill_o = 1'b0;
        if (en_i) begin
            if (req_cpu_i && (!req_fill_i || last_fill_q)) begin
                gnt_cpu_o = 1'b1;
            end else if (req_fill_i) begin
                gnt_fill_o = 1'b1;
            end else begin
                gnt_cpu_o  = 1'b0;
                gnt_fill_o = 1'b0;
            end
        end else begin
            gnt_cpu_o  = 1'b0;
            gnt_fill_o = 1'b0;
        end
    end

    // Remember which source won the most recent grant.
    always_comb begin
        last_fill_d = last_fill_q;
        if (gnt_cpu_o) begin
            last_fill_d = 1'b0;
        end else if (gnt_fill_o) begin
            last_fill_d = 1'b1;
        end else begin
            last_fill_d = last_fill_q;
        end
    end

    // Last-grant register; reset makes the CPU the next contended winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_fill_q <= 1'b1;
        end else begin
            last_fill_q <= last_fill_d;
        end
    end

endmodule : fb_rr_arbiter

// File: rtl/fb_write_scheduler.sv
// Framebuffer write scheduler: merges CPU row writes and a whole-buffer fill
// into one paced stream of fb_set_data strobes. Each grant produces one
// strobe the following cycle, then the block holds off so strobes are at
// least HOLD_CYCLES+1 cycles apart.
module fb_write_scheduler
    import baby_vga_pkg::*;
#(
    parameter int ADDR_BITS   = FB_ADDR_BITS,
    parameter int HOLD_CYCLES = FB_HOLD_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_wr_valid,
    output logic                  cpu_wr_ready,
    input  logic [ADDR_BITS-1:0]  cpu_wr_addr,
    input  logic [FB_DATA_W-1:0]  cpu_wr_data,
    input  logic                  fill_start,
    input  logic [FB_DATA_W-1:0]  fill_pattern,
    output logic                  fill_busy,
    output logic                  fill_done,
    output logic [FB_CNT_W-1:0]   fb_counter,
    output logic [ADDR_BITS-1:0]  fb_w_addr,
    output logic [FB_DATA_W-1:0]  fb_data_in,
    output logic                  fb_set_data,
    output logic                  busy
);

    // HOLD lasts HOLD_CYCLES-1 cycles: the counter runs 0 .. HOLD_CYCLES-2.
    localparam int                   HC_W      = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0]      HOLD_LAST = HC_W'(HOLD_CYCLES - 2);
    localparam logic [ADDR_BITS-1:0] LAST_ROW  = {ADDR_BITS{1'b1}};

    fb_state_e              state_q, state_d;
    logic [HC_W-1:0]        hold_cnt_q, hold_cnt_d;
    logic [FB_CNT_W-1:0]    fb_counter_q;
    logic                   fb_set_data_q, fb_set_data_d;
    logic [ADDR_BITS-1:0]   fb_w_addr_q, fb_w_addr_d;
    logic [FB_DATA_W-1:0]   fb_data_in_q, fb_data_in_d;
    logic                   fill_busy_q, fill_busy_d;
    logic                   fill_done_q, fill_done_d;
    logic [ADDR_BITS-1:0]   fill_idx_q, fill_idx_d;
    logic [FB_DATA_W-1:0]   fill_pat_q, fill_pat_d;
    logic                   busy_q, busy_d;

    logic                   arb_en_s;
    logic                   gnt_cpu_s;
    logic                   gnt_fill_s;
    logic                   gnt_any_s;
    logic                   fill_accept_s;

    // Arbitration only happens in IDLE and never while reset is asserted,
    // so the CPU cannot be handshaken during reset.
    assign arb_en_s      = (state_q == ST_IDLE) && !rst;
    assign gnt_any_s     = gnt_cpu_s || gnt_fill_s;
    // A new fill is refused while one is running or just finishing.
    assign fill_accept_s = fill_start && !fill_busy_q && !fill_done_q;

    fb_rr_arbiter u_arb (
        .clk        (clk),
        .rst        (rst),
        .en_i       (arb_en_s),
        .req_cpu_i  (cpu_wr_valid),
        .req_fill_i (fill_busy_q),
        .gnt_cpu_o  (gnt_cpu_s),
        .gnt_fill_o (gnt_fill_s)
    );

    // Write pacing FSM: IDLE grants, ISSUE strobes, HOLD spaces the strobes.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any_s) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d    = ST_HOLD;
                hold_cnt_d = '0;
            end
            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
            end
        endcase
    end

    // Capture the granted row/data; they stay stable until the next grant.
    always_comb begin
        fb_w_addr_d   = fb_w_addr_q;
        fb_data_in_d  = fb_data_in_q;
        fb_set_data_d = gnt_any_s;
        if (gnt_cpu_s) begin
            fb_w_addr_d  = cpu_wr_addr;
            fb_data_in_d = cpu_wr_data;
        end else if (gnt_fill_s) begin
            fb_w_addr_d  = fill_idx_q;
            fb_data_in_d = fill_pat_q;
        end else begin
            fb_w_addr_d  = fb_w_addr_q;
            fb_data_in_d = fb_data_in_q;
        end
    end

    // Fill engine: arm on an accepted start, walk rows on each fill grant,
    // and flag completion alongside the last row's strobe.
    always_comb begin
        fill_busy_d = fill_busy_q;
        fill_idx_d  = fill_idx_q;
        fill_pat_d  = fill_pat_q;
        fill_done_d = 1'b0;
        if (fill_accept_s) begin
            fill_busy_d = 1'b1;
            fill_idx_d  = '0;
            fill_pat_d  = fill_pattern;
        end else if (gnt_fill_s) begin
            fill_idx_d = fill_idx_q + ADDR_BITS'(1);
            if (fill_idx_q == LAST_ROW) begin
                fill_busy_d = 1'b0;
                fill_done_d = 1'b1;
            end else begin
                fill_busy_d = 1'b1;
            end
        end else begin
            fill_busy_d = fill_busy_q;
        end
    end

    // Busy is registered from the next-state view so it lines up with state.
    always_comb begin
        busy_d = (state_d != ST_IDLE) || fill_busy_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            hold_cnt_q    <= '0;
            fb_counter_q  <= 3'd0;
            fb_set_data_q <= 1'b0;
            fb_w_addr_q   <= '0;
            fb_data_in_q  <= 32'd0;
            fill_busy_q   <= 1'b0;
            fill_done_q   <= 1'b0;
            fill_idx_q    <= '0;
            fill_pat_q    <= 32'd0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            fb_counter_q  <= fb_counter_q + 3'd1;
            fb_set_data_q <= fb_set_data_d;
            fb_w_addr_q   <= fb_w_addr_d;
            fb_data_in_q  <= fb_data_in_d;
            fill_busy_q   <= fill_busy_d;
            fill_done_q   <= fill_done_d;
            fill_idx_q    <= fill_idx_d;
            fill_pat_q    <= fill_pat_d;
            busy_q        <= busy_d;
        end
    end

    assign cpu_wr_ready = gnt_cpu_s;
    assign fill_busy    = fill_busy_q;
    assign fill_done    = fill_done_q;
    assign fb_counter   = fb_counter_q;
    assign fb_w_addr    = fb_w_addr_q;
    assign fb_data_in   = fb_data_in_q;
    assign fb_set_data  = fb_set_data_q;
    assign busy         = busy_q;

endmodule : fb_write_scheduler

// File: tb/tb_fb_write_scheduler.sv
// Testbench for fb_write_scheduler: directed scenarios plus a randomized run,
// all checked against a timing-level reference model (cycles since the last
// grant, a row queue for the fill, and a last-winner flag).
module tb_fb_write_scheduler;

    localparam int HC   = 8;
    localparam int ROWS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_wr_valid = 1'b0;
    logic [3:0]  cpu_wr_addr = 4'd0;
    logic [31:0] cpu_wr_data = 32'd0;
    logic        fill_start = 1'b0;
    logic [31:0] fill_pattern = 32'd0;
    logic        cpu_wr_ready, fill_busy, fill_done, fb_set_data, busy;
    logic [2:0]  fb_counter;
    logic [3:0]  fb_w_addr;
    logic [31:0] fb_data_in;

    always #5 clk = ~clk;

    fb_write_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_wr_valid (cpu_wr_valid),
        .cpu_wr_ready (cpu_wr_ready),
        .cpu_wr_addr  (cpu_wr_addr),
        .cpu_wr_data  (cpu_wr_data),
        .fill_start   (fill_start),
        .fill_pattern (fill_pattern),
        .fill_busy    (fill_busy),
        .fill_done    (fill_done),
        .fb_counter   (fb_counter),
        .fb_w_addr    (fb_w_addr),
        .fb_data_in   (fb_data_in),
        .fb_set_data  (fb_set_data),
        .busy         (busy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_since = HC + 1;   // cycles since last grant (saturating)
    logic [2:0]  m_cnt = 3'd0;
    logic [3:0]  m_addr = 4'd0;
    logic [31:0] m_data = 32'd0;
    bit          m_fbusy = 1'b0, m_fdone = 1'b0, m_last_fill = 1'b1;
    int          m_idx = 0;
    logic [31:0] m_pat = 32'd0;
    bit          e_ready, e_gfill, e_pulse, e_busy;

    // Snapshots of one cycle: observed (o_) and model (x_)
    logic        o_ready, o_pulse, o_busy, o_fbusy, o_fdone;
    logic [2:0]  o_cnt;
    logic [3:0]  o_addr;
    logic [31:0] o_data;
    logic [3:0]  x_addr;
    logic [31:0] x_data;
    logic        x_fbusy, x_fdone;
    logic [2:0]  x_cnt;

    task automatic model_eval();
        bit idle;
        idle    = (m_since > HC) && !rst;
        e_ready = idle && cpu_wr_valid && (!m_fbusy || m_last_fill);
        e_gfill = idle && m_fbusy && !e_ready;
        e_pulse = (m_since == 1);
        e_busy  = (m_since <= HC) || m_fbusy;
    endtask

    task automatic model_update();
        bit acc;
        acc = fill_start && !m_fbusy && !m_fdone;
        if (rst) begin
            m_since = HC + 1; m_cnt = 3'd0; m_addr = 4'd0; m_data = 32'd0;
            m_fbusy = 1'b0; m_fdone = 1'b0; m_idx = 0; m_pat = 32'd0; m_last_fill = 1'b1;
        end else begin
            m_cnt   = m_cnt + 3'd1;
            m_fdone = 1'b0;
            if (e_ready) begin
                m_addr = cpu_wr_addr; m_data = cpu_wr_data; m_since = 1; m_last_fill = 1'b0;
            end else if (e_gfill) begin
                m_addr = 4'(m_idx); m_data = m_pat; m_since = 1; m_last_fill = 1'b1;
                if (m_idx == ROWS - 1) begin
                    m_fbusy = 1'b0; m_fdone = 1'b1;
                end
                m_idx = (m_idx + 1) % ROWS;
            end else if (m_since <= HC) begin
                m_since++;
            end
            if (acc) begin
                m_fbusy = 1'b1; m_idx = 0; m_pat = fill_pattern;
            end
        end
    endtask

    // Advance one cycle: inputs are already driven (at the falling edge).
    task automatic cyc_step();
        #1;
        model_eval();
        o_ready = cpu_wr_ready; o_pulse = fb_set_data; o_busy = busy;
        o_fbusy = fill_busy; o_fdone = fill_done; o_cnt = fb_counter;
        o_addr = fb_w_addr; o_data = fb_data_in;
        x_addr = m_addr; x_data = m_data; x_fbusy = m_fbusy; x_fdone = m_fdone; x_cnt = m_cnt;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        cpu_wr_valid = 1'b0; fill_start = 1'b0; rst = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            cyc_step();
            if (o_busy === 1'b0 && o_fbusy === 1'b0) ok = 1'b1;
        end
        total++;
        if (!ok) begin bad++; $display("FAIL wait_idle: busy never dropped (busy=%b fill_busy=%b)", o_busy, o_fbusy); end
    endtask

    task automatic test_reset();
        rst = 1'b1; cpu_wr_valid = 1'b1; cpu_wr_addr = 4'($urandom); fill_start = 1'b1;
        cyc_step();
        cyc_step();
        total++;
        if (o_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", o_ready); end
        rst = 1'b0; cpu_wr_valid = 1'b0; fill_start = 1'b0;
        cyc_step();
        total++;
        if (o_pulse !== 1'b0 || o_busy !== 1'b0 || o_fbusy !== 1'b0 || o_fdone !== 1'b0) begin
            bad++; $display("FAIL reset_flags: set_data=%b busy=%b fill_busy=%b fill_done=%b want all 0",
                            o_pulse, o_busy, o_fbusy, o_fdone);
        end
        total++;
        if (o_addr !== 4'd0 || o_data !== 32'd0 || o_cnt !== 3'd0) begin
            bad++; $display("FAIL reset_values: addr=%h data=%h counter=%0d want 0/0/0", o_addr, o_data, o_cnt);
        end
    endtask

    task automatic test_single_write();
        int busy_cnt = 0, extra = 0;
        rst = 1'b1; cpu_wr_valid = 1'b0; fill_start = 1'b0;
        cyc_step();
        rst = 1'b0; cpu_wr_valid = 1'b1; cpu_wr_addr = 4'd3; cpu_wr_data = 32'hDEADBEEF;
        cyc_step();
        total++;
        if (o_ready !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", o_ready); end
        cpu_wr_valid = 1'b0; cpu_wr_data = $urandom;
        cyc_step();
        total++;
        if (o_pulse !== 1'b1 || o_addr !== 4'd3 || o_data !== 32'hDEADBEEF) begin
            bad++; $display("FAIL single_pulse: set=%b addr=%h data=%h want 1/3/deadbeef", o_pulse, o_addr, o_data);
        end
        if (o_busy === 1'b1) busy_cnt++;
        for (int c = 0; c < 12; c++) begin
            cyc_step();
            if (o_busy === 1'b1) busy_cnt++;
            if (o_pulse === 1'b1) extra++;
        end
        total++;
        if (busy_cnt != 8) begin bad++; $display("FAIL single_busy_len: got %0d want 8", busy_cnt); end
        total++;
        if (extra != 0) begin bad++; $display("FAIL single_extra_pulse: got %0d want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int pulses[$];
        int readies[$];
        logic [31:0] sent[$];
        wait_idle();
        cpu_wr_valid = 1'b1; cpu_wr_addr = 4'($urandom); cpu_wr_data = $urandom;
        for (int c = 0; c < 40; c++) begin
            cyc_step();
            if (o_ready === 1'b1) begin
                readies.push_back(c); sent.push_back(cpu_wr_data); cpu_wr_data = $urandom;
            end
            if (o_pulse === 1'b1) begin
                pulses.push_back(c);
                total++;
                if (sent.size() == 0 || o_data !== sent[0] || o_addr !== cpu_wr_addr) begin
                    bad++; $display("FAIL b2b_data: addr=%h data=%h want addr=%h data=%h", o_addr, o_data,
                                    cpu_wr_addr, (sent.size() > 0) ? sent[0] : 32'd0);
                end
                if (sent.size() > 0) void'(sent.pop_front());
            end
        end
        cpu_wr_valid = 1'b0;
        total++;
        if (pulses.size() != 5 || readies.size() != 5) begin
            bad++; $display("FAIL b2b_count: pulses=%0d readies=%0d want 5/5", pulses.size(), readies.size());
        end
        for (int i = 1; i < pulses.size(); i++) begin
            total++;
            if (pulses[i] - pulses[i-1] != 9) begin
                bad++; $display("FAIL b2b_spacing: got %0d want 9", pulses[i] - pulses[i-1]);
            end
        end
        for (int i = 1; i < readies.size(); i++) begin
            total++;
            if (readies[i] - readies[i-1] != 9) begin
                bad++; $display("FAIL b2b_ready_in_hold: ready gap %0d want 9", readies[i] - readies[i-1]);
            end
        end
    endtask

    task automatic test_fill(input bit spam);
        int n = 0;
        bit done_seen = 1'b0;
        logic exp_done;
        wait_idle();
        fill_pattern = 32'h0F0F0F0F; fill_start = 1'b1;
        cyc_step();
        fill_start = 1'b0;
        for (int c = 0; c < 400 && !done_seen; c++) begin
            if (spam) begin fill_start = 1'($urandom_range(0, 1)); fill_pattern = $urandom; end
            cyc_step();
            if (o_pulse === 1'b1) begin
                total++;
                if (o_addr !== 4'(n) || o_data !== 32'h0F0F0F0F) begin
                    bad++; $display("FAIL fill_row: addr=%h data=%h want %h/0f0f0f0f", o_addr, o_data, 4'(n));
                end
                n++;
            end
            exp_done = (o_pulse === 1'b1) && (n == ROWS);
            total++;
            if (o_fdone !== exp_done) begin bad++; $display("FAIL fill_done_timing: got %b want %b row=%0d", o_fdone, exp_done, n); end
            if (o_fdone === 1'b1) begin
                done_seen = 1'b1;
            end else begin
                total++;
                if (o_fbusy !== 1'b1) begin bad++; $display("FAIL fill_busy_low: got %b want 1", o_fbusy); end
            end
        end
        fill_start = 1'b0;
        total++;
        if (!done_seen || n != ROWS) begin bad++; $display("FAIL fill_count: pulses=%0d done=%b want 16/1", n, done_seen); end
        cyc_step();
        total++;
        if (o_fbusy !== 1'b0) begin bad++; $display("FAIL fill_busy_after: got %b want 0", o_fbusy); end
    endtask

    task automatic test_fill_cpu();
        logic [31:0] pat, cd;
        logic [31:0] sent[$];
        int issues = 0, k = 0;
        bit done = 1'b0;
        // Phase A: fill_start together with a CPU write, CPU served first.
        wait_idle();
        pat = $urandom; cd = $urandom;
        fill_start = 1'b1; fill_pattern = pat; cpu_wr_valid = 1'b1; cpu_wr_addr = 4'd9; cpu_wr_data = cd;
        cyc_step();
        total++;
        if (o_ready !== 1'b1) begin bad++; $display("FAIL fc_same_cycle_ready: got %b want 1", o_ready); end
        fill_start = 1'b0; cpu_wr_valid = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            cyc_step();
            if (o_pulse === 1'b1) begin
                total++;
                if (issues == 0 ? (o_addr !== 4'd9 || o_data !== cd) : (o_addr !== 4'(issues - 1) || o_data !== pat)) begin
                    bad++; $display("FAIL fc_issue%0d: addr=%h data=%h", issues, o_addr, o_data);
                end
                issues++;
            end
            if (o_fdone === 1'b1) done = 1'b1;
        end
        total++;
        if (!done || issues != 17) begin bad++; $display("FAIL fc_total_issues: got %0d done=%b want 17/1", issues, done); end
        // Phase B: CPU valid held through the whole fill, grants alternate.
        wait_idle();
        pat = $urandom; done = 1'b0;
        fill_start = 1'b1; fill_pattern = pat; cpu_wr_valid = 1'b1; cpu_wr_addr = 4'd9; cpu_wr_data = $urandom;
        for (int c = 0; c < 500 && !done; c++) begin
            cyc_step();
            fill_start = 1'b0;
            if (o_ready === 1'b1) begin sent.push_back(cpu_wr_data); cpu_wr_data = $urandom; end
            if (o_pulse === 1'b1) begin
                total++;
                if (k % 2 == 0) begin
                    if (sent.size() == 0 || o_addr !== 4'd9 || o_data !== sent[0]) begin
                        bad++; $display("FAIL fc_alt_cpu k=%0d: addr=%h data=%h", k, o_addr, o_data);
                    end
                    if (sent.size() > 0) void'(sent.pop_front());
                end else if (o_addr !== 4'((k - 1) / 2) || o_data !== pat) begin
                    bad++; $display("FAIL fc_alt_fill k=%0d: addr=%h data=%h want %h/%h", k, o_addr, o_data, 4'((k - 1) / 2), pat);
                end
                k++;
            end
            if (o_fdone === 1'b1) done = 1'b1;
        end
        cpu_wr_valid = 1'b0;
        total++;
        if (!done || k != 32) begin bad++; $display("FAIL fc_alt_total: got %0d done=%b want 32/1", k, done); end
    endtask

    task automatic test_reset_mid_fill();
        bit found = 1'b0;
        int pulses = 0;
        wait_idle();
        fill_start = 1'b1; fill_pattern = $urandom;
        cyc_step();
        fill_start = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            cyc_step();
            if (o_pulse === 1'b1 && o_addr === 4'd5) found = 1'b1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL rmf_row5: row 5 never issued"); end
        rst = 1'b1;
        cyc_step();
        rst = 1'b0;
        cyc_step();
        total++;
        if (o_cnt !== 3'd0 || o_fbusy !== 1'b0 || o_pulse !== 1'b0 || o_busy !== 1'b0) begin
            bad++; $display("FAIL rmf_after: counter=%0d fill_busy=%b set=%b busy=%b want 0/0/0/0", o_cnt, o_fbusy, o_pulse, o_busy);
        end
        for (int c = 0; c < 40; c++) begin
            cyc_step();
            if (o_pulse === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin bad++; $display("FAIL rmf_no_pulses: got %0d want 0", pulses); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst          = ($urandom_range(0, 149) == 0);
            cpu_wr_valid = ($urandom_range(0, 2) != 0);
            cpu_wr_addr  = 4'($urandom);
            cpu_wr_data  = $urandom;
            fill_start   = ($urandom_range(0, 39) == 0);
            fill_pattern = $urandom;
            cyc_step();
            total++;
            if (o_ready !== e_ready || o_pulse !== e_pulse || o_busy !== e_busy) begin
                bad++; $display("FAIL rand_ctrl c=%0d: ready=%b set=%b busy=%b want %b/%b/%b",
                                c, o_ready, o_pulse, o_busy, e_ready, e_pulse, e_busy);
            end
            total++;
            if (o_fbusy !== x_fbusy || o_fdone !== x_fdone || o_cnt !== x_cnt) begin
                bad++; $display("FAIL rand_fill c=%0d: fill_busy=%b fill_done=%b counter=%0d want %b/%b/%0d",
                                c, o_fbusy, o_fdone, o_cnt, x_fbusy, x_fdone, x_cnt);
            end
            total++;
            if (o_addr !== x_addr || o_data !== x_data) begin
                bad++; $display("FAIL rand_data c=%0d: addr=%h data=%h want %h/%h", c, o_addr, o_data, x_addr, x_data);
            end
        end
        rst = 1'b0; cpu_wr_valid = 1'b0; fill_start = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_write();
        test_back_to_back();
        test_fill(1'b0);
        test_fill(1'b1);
        test_fill_cpu();
        test_reset_mid_fill();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule : tb_fb_write_scheduler
